// File: rtl/trg_ack_monitor_if.sv
// Trigger/acknowledge bundle seen by trg_ack_monitor: TRG/ACK/mask/clear in, result and stats out.
// ACK_MISSING_STICKY exists only when TRG_ACK_STICKY_EN is defined.
interface trg_ack_monitor_if #(
  parameter int N_SCROD = 12,
  parameter int CNT_W   = 16
) ();

  logic [N_SCROD-1:0] TRG;
  logic [N_SCROD-1:0] ACK;
  logic [N_SCROD-1:0] TRG_MASK;
  logic               CLR_STATS;
  logic               BUSY;
  logic               RESULT_VALID;
  logic [N_SCROD-1:0] ACK_RECEIVED;
  logic [N_SCROD-1:0] ACK_MISSING;
  logic [7:0]         ACK_LATENCY;
  logic [CNT_W-1:0]   TRG_COUNT;
  logic [CNT_W-1:0]   TIMEOUT_COUNT;
  logic [CNT_W-1:0]   OVERLAP_COUNT;
`ifdef TRG_ACK_STICKY_EN
  logic [N_SCROD-1:0] ACK_MISSING_STICKY;
`endif

  modport master (
    output TRG, ACK, TRG_MASK, CLR_STATS,
    input  BUSY, RESULT_VALID, ACK_RECEIVED, ACK_MISSING, ACK_LATENCY,
           TRG_COUNT, TIMEOUT_COUNT, OVERLAP_COUNT
`ifdef TRG_ACK_STICKY_EN
           , ACK_MISSING_STICKY
`endif
  );

  modport slave (
    input  TRG, ACK, TRG_MASK, CLR_STATS,
    output BUSY, RESULT_VALID, ACK_RECEIVED, ACK_MISSING, ACK_LATENCY,
           TRG_COUNT, TIMEOUT_COUNT, OVERLAP_COUNT
`ifdef TRG_ACK_STICKY_EN
           , ACK_MISSING_STICKY
`endif
  );

endinterface

// File: rtl/trg_ack_monitor.sv
// Checks which enabled SCRODs acknowledge each issued trigger within ACK_TIMEOUT cycles and keeps
// saturating health counters. Define TRG_ACK_STICKY_EN to add the ACK_MISSING_STICKY accumulator.
module trg_ack_monitor #(
  parameter int ACK_TIMEOUT = 200,
  parameter int CNT_W       = 16,
  parameter int N_SCROD     = 12
) (
  input  logic             CLK_80MHZ,
  input  logic             RESET,
  trg_ack_monitor_if.slave bus
);

  // Wide enough for the wait counter plus one, and never narrower than the 255 latency ceiling.
  localparam int CYC_W = ($clog2(ACK_TIMEOUT + 1) > 8) ? $clog2(ACK_TIMEOUT + 1) + 1 : 9;
  localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(ACK_TIMEOUT - 1);
  localparam logic [CYC_W-1:0] LAT_MAX      = CYC_W'(255);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [N_SCROD-1:0] ack_meta_q, ack_meta_d;
  logic [N_SCROD-1:0] ack_sync_q, ack_sync_d;
  logic [N_SCROD-1:0] ack_prev_q, ack_prev_d;
  logic [N_SCROD-1:0] ack_edge_q, ack_edge_d;
  logic               trg_any_q, trg_any_d;
  logic               trg_prev_q, trg_prev_d;

  logic [N_SCROD-1:0] expect_q, expect_d;
  logic [N_SCROD-1:0] rcv_q, rcv_d;
  logic [CYC_W-1:0]   cnt_q, cnt_d;

  logic [CNT_W-1:0]   trg_count_q, trg_count_d;
  logic [CNT_W-1:0]   timeout_count_q, timeout_count_d;
  logic [CNT_W-1:0]   overlap_count_q, overlap_count_d;

  logic               result_valid_q, result_valid_d;
  logic [N_SCROD-1:0] ack_received_q, ack_received_d;
  logic [N_SCROD-1:0] ack_missing_q, ack_missing_d;
  logic [7:0]         ack_latency_q, ack_latency_d;

  logic               trg_edge;
  logic [N_SCROD-1:0] rcv_next;
  logic [N_SCROD-1:0] missing_new;
  logic [CYC_W-1:0]   cnt_inc;
  logic               load_result;
  logic [7:0]         latency_new;
  logic               trg_inc;
  logic               tmo_inc;
  logic               ovl_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  always_comb begin
    ack_meta_d = bus.ACK;
    ack_sync_d = ack_meta_q;
    ack_prev_d = ack_sync_q;
    ack_edge_d = ack_sync_q & ~ack_prev_q;
    trg_any_d  = |(bus.TRG & bus.TRG_MASK);
    trg_prev_d = trg_any_q;
    trg_edge   = trg_any_q & ~trg_prev_q;
  end

  // Edges that complete the set on the very cycle the counter expires still win over the timeout.
  always_comb begin
    state_d     = state_q;
    expect_d    = expect_q;
    rcv_d       = rcv_q;
    cnt_d       = cnt_q;
    load_result = 1'b0;
    latency_new = 8'h00;
    trg_inc     = 1'b0;
    tmo_inc     = 1'b0;
    ovl_inc     = 1'b0;
    rcv_next    = rcv_q | (ack_edge_q & expect_q);
    missing_new = expect_q & ~rcv_next;
    cnt_inc     = cnt_q + CYC_W'(1);

    case (state_q)
      S_IDLE: begin
        if (trg_edge) begin
          state_d  = S_WAIT;
          expect_d = bus.TRG_MASK;
          rcv_d    = '0;
          cnt_d    = '0;
          trg_inc  = 1'b1;
        end
      end
      S_WAIT: begin
        ovl_inc = trg_edge;
        rcv_d   = rcv_next;
        cnt_d   = cnt_inc;
        if (rcv_next == expect_q) begin
          state_d     = S_REPORT;
          load_result = 1'b1;
          latency_new = (cnt_inc > LAT_MAX) ? 8'hFF : cnt_inc[7:0];
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d     = S_REPORT;
          load_result = 1'b1;
          tmo_inc     = 1'b1;
          latency_new = 8'hFF;
        end
      end
      S_REPORT: begin
        ovl_inc = trg_edge;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    result_valid_d = load_result;
    ack_received_d = ack_received_q;
    ack_missing_d  = ack_missing_q;
    ack_latency_d  = ack_latency_q;
    if (load_result) begin
      ack_received_d = rcv_next;
      ack_missing_d  = missing_new;
      ack_latency_d  = latency_new;
    end
  end

  // A clear request beats any increment landing on the same edge.
  always_comb begin
    trg_count_d     = trg_count_q;
    timeout_count_d = timeout_count_q;
    overlap_count_d = overlap_count_q;
    if (bus.CLR_STATS) begin
      trg_count_d     = '0;
      timeout_count_d = '0;
      overlap_count_d = '0;
    end else begin
      if (trg_inc) trg_count_d     = sat_inc(trg_count_q);
      if (tmo_inc) timeout_count_d = sat_inc(timeout_count_q);
      if (ovl_inc) overlap_count_d = sat_inc(overlap_count_q);
    end
  end

  always_ff @(posedge CLK_80MHZ or posedge RESET) begin
    if (RESET) begin
      state_q         <= S_IDLE;
      ack_meta_q      <= '0;
      ack_sync_q      <= '0;
      ack_prev_q      <= '0;
      ack_edge_q      <= '0;
      trg_any_q       <= 1'b0;
      trg_prev_q      <= 1'b0;
      expect_q        <= '0;
      rcv_q           <= '0;
      cnt_q           <= '0;
      trg_count_q     <= '0;
      timeout_count_q <= '0;
      overlap_count_q <= '0;
      result_valid_q  <= 1'b0;
      ack_received_q  <= '0;
      ack_missing_q   <= '0;
      ack_latency_q   <= '0;
    end else begin
      state_q         <= state_d;
      ack_meta_q      <= ack_meta_d;
      ack_sync_q      <= ack_sync_d;
      ack_prev_q      <= ack_prev_d;
      ack_edge_q      <= ack_edge_d;
      trg_any_q       <= trg_any_d;
      trg_prev_q      <= trg_prev_d;
      expect_q        <= expect_d;
      rcv_q           <= rcv_d;
      cnt_q           <= cnt_d;
      trg_count_q     <= trg_count_d;
      timeout_count_q <= timeout_count_d;
      overlap_count_q <= overlap_count_d;
      result_valid_q  <= result_valid_d;
      ack_received_q  <= ack_received_d;
      ack_missing_q   <= ack_missing_d;
      ack_latency_q   <= ack_latency_d;
    end
  end

  assign bus.BUSY          = (state_q == S_WAIT);
  assign bus.RESULT_VALID  = result_valid_q;
  assign bus.ACK_RECEIVED  = ack_received_q;
  assign bus.ACK_MISSING   = ack_missing_q;
  assign bus.ACK_LATENCY   = ack_latency_q;
  assign bus.TRG_COUNT     = trg_count_q;
  assign bus.TIMEOUT_COUNT = timeout_count_q;
  assign bus.OVERLAP_COUNT = overlap_count_q;

`ifdef TRG_ACK_STICKY_EN
  logic [N_SCROD-1:0] sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if (bus.CLR_STATS)     sticky_d = '0;
    else if (load_result)  sticky_d = sticky_q | missing_new;
  end

  always_ff @(posedge CLK_80MHZ or posedge RESET) begin
    if (RESET) sticky_q <= '0;
    else       sticky_q <= sticky_d;
  end

  assign bus.ACK_MISSING_STICKY = sticky_q;
`endif

  a_valid_single: assert property (@(posedge CLK_80MHZ) disable iff (RESET)
    result_valid_q |=> !result_valid_q);
  a_masks_disjoint: assert property (@(posedge CLK_80MHZ) disable iff (RESET)
    (ack_received_q & ack_missing_q) == '0);

endmodule

// File: tb/tb_trg_ack_monitor.sv
// Directed bench for trg_ack_monitor: stimulus pushes expected results, a negedge monitor pops and compares.
// Built with CNT_W=4 so counter saturation is reachable; sticky checks run when TRG_ACK_STICKY_EN is defined.
module tb_trg_ack_monitor;

  localparam int N  = 12;
  localparam int CW = 4;

  typedef struct {
    int         at;
    logic [N-1:0] rcv;
    logic [N-1:0] miss;
    logic [7:0] lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  int   c0;

  trg_ack_monitor_if #(.N_SCROD(N), .CNT_W(CW)) bus ();

  trg_ack_monitor #(.ACK_TIMEOUT(200), .CNT_W(CW), .N_SCROD(N)) dut (
    .CLK_80MHZ (clk),
    .RESET     (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] trg, input logic [N-1:0] ack, input int cycles);
    bus.TRG = trg;
    bus.ACK = ack;
    tick(cycles);
  endtask

  task automatic expectResult(input int at, input logic [N-1:0] r, input logic [N-1:0] m, input logic [7:0] l);
    exp_t e;
    e.at = at; e.rcv = r; e.miss = m; e.lat = l;
    sb_q.push_back(e);
  endtask

  // Result monitor: every RESULT_VALID must match the oldest outstanding expectation, including its cycle.
  always @(negedge clk) begin
    if (!rst && bus.RESULT_VALID) begin
      checkOutput("result_expected", (sb_q.size() > 0) ? 1 : 0, 1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        checkOutput("result_cycle", cyc, mon_e.at);
        checkOutput("ack_received", int'(bus.ACK_RECEIVED), int'(mon_e.rcv));
        checkOutput("ack_missing", int'(bus.ACK_MISSING), int'(mon_e.miss));
        checkOutput("ack_latency", int'(bus.ACK_LATENCY), int'(mon_e.lat));
      end
    end
  end

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, int'(bus.BUSY), 0);
    checkOutput({tag, "_valid"}, int'(bus.RESULT_VALID), 0);
    checkOutput({tag, "_received"}, int'(bus.ACK_RECEIVED), 0);
    checkOutput({tag, "_missing"}, int'(bus.ACK_MISSING), 0);
    checkOutput({tag, "_latency"}, int'(bus.ACK_LATENCY), 0);
    checkOutput({tag, "_trg_count"}, int'(bus.TRG_COUNT), 0);
    checkOutput({tag, "_timeout_count"}, int'(bus.TIMEOUT_COUNT), 0);
    checkOutput({tag, "_overlap_count"}, int'(bus.OVERLAP_COUNT), 0);
  endtask

  initial begin
    bus.TRG = '0;
    bus.ACK = '0;
    bus.TRG_MASK = '0;
    bus.CLR_STATS = 1'b0;
    tick(3);
    checkIdleOutputs("reset");
    rst = 1'b0;
    tick(2);

    // Complete acknowledge: ACK rises 10 cycles after TRG, latency 12.
    $display("[TB] complete acknowledge");
    bus.TRG_MASK = 12'h00F;
    tick(1);
    c0 = cyc;
    expectResult(c0 + 14, 12'h00F, 12'h000, 8'd12);
    applyStimulus(12'h001, 12'h000, 1);
    applyStimulus(12'h000, 12'h000, 4);
    checkOutput("busy_in_wait", int'(bus.BUSY), 1);
    applyStimulus(12'h000, 12'h000, 5);
    applyStimulus(12'h000, 12'h00F, 8);
    checkOutput("trg_count_1", int'(bus.TRG_COUNT), 1);
    checkOutput("timeout_count_0", int'(bus.TIMEOUT_COUNT), 0);
    checkOutput("busy_after", int'(bus.BUSY), 0);
    applyStimulus(12'h000, 12'h000, 4);

    // Timeout: only lane 0 of 0x003 answers.
    $display("[TB] timeout");
    bus.TRG_MASK = 12'h003;
    c0 = cyc;
    expectResult(c0 + 202, 12'h001, 12'h002, 8'd255);
    applyStimulus(12'h001, 12'h000, 1);
    applyStimulus(12'h000, 12'h000, 9);
    applyStimulus(12'h000, 12'h001, 195);
    checkOutput("timeout_count_1", int'(bus.TIMEOUT_COUNT), 1);
    checkOutput("trg_count_2", int'(bus.TRG_COUNT), 2);
    applyStimulus(12'h000, 12'h000, 4);

    // Filtering and overlap: stray lane 5 and a second trigger edge while waiting.
    $display("[TB] filtering and overlap");
    bus.TRG_MASK = 12'h001;
    c0 = cyc;
    expectResult(c0 + 34, 12'h001, 12'h000, 8'd32);
    applyStimulus(12'h001, 12'h000, 1);
    applyStimulus(12'h000, 12'h000, 4);
    applyStimulus(12'h000, 12'h020, 15);
    applyStimulus(12'h001, 12'h020, 1);
    applyStimulus(12'h000, 12'h020, 9);
    applyStimulus(12'h000, 12'h021, 8);
    checkOutput("overlap_count_1", int'(bus.OVERLAP_COUNT), 1);
    checkOutput("trg_count_3", int'(bus.TRG_COUNT), 3);
    applyStimulus(12'h000, 12'h000, 4);

    bus.TRG_MASK = 12'h000;
    for (int i = 0; i < 6; i++) begin
      applyStimulus((i % 2 == 0) ? 12'hFFF : 12'h000, 12'h000, 1);
      checkOutput("busy_mask_zero", int'(bus.BUSY), 0);
    end
    applyStimulus(12'h000, 12'h000, 4);
    checkOutput("trg_count_mask_zero", int'(bus.TRG_COUNT), 3);

    // Boundary: the last acknowledge lands on the timeout cycle and completes the set.
    $display("[TB] edge on timeout cycle");
    bus.TRG_MASK = 12'h003;
    c0 = cyc;
    expectResult(c0 + 202, 12'h003, 12'h000, 8'd200);
    applyStimulus(12'h001, 12'h000, 1);
    applyStimulus(12'h000, 12'h000, 9);
    applyStimulus(12'h000, 12'h001, 188);
    applyStimulus(12'h000, 12'h003, 8);
    checkOutput("timeout_count_unchanged", int'(bus.TIMEOUT_COUNT), 1);
    checkOutput("trg_count_4", int'(bus.TRG_COUNT), 4);
    applyStimulus(12'h000, 12'h000, 4);

    // CLR_STATS on the same edge as a trigger start.
    $display("[TB] clear coincident with start");
    bus.TRG_MASK = 12'h001;
    c0 = cyc;
    expectResult(c0 + 14, 12'h001, 12'h000, 8'd12);
    applyStimulus(12'h001, 12'h000, 1);
    bus.CLR_STATS = 1'b1;
    applyStimulus(12'h000, 12'h000, 1);
    bus.CLR_STATS = 1'b0;
    applyStimulus(12'h000, 12'h000, 8);
    applyStimulus(12'h000, 12'h001, 8);
    checkOutput("clr_trg_count", int'(bus.TRG_COUNT), 0);
    checkOutput("clr_timeout_count", int'(bus.TIMEOUT_COUNT), 0);
    checkOutput("clr_overlap_count", int'(bus.OVERLAP_COUNT), 0);
    applyStimulus(12'h000, 12'h000, 4);

    // Saturation: 20 quick triggers on a 4-bit counter.
    $display("[TB] counter saturation");
    for (int i = 0; i < 20; i++) begin
      c0 = cyc;
      expectResult(c0 + 6, 12'h001, 12'h000, 8'd4);
      applyStimulus(12'h001, 12'h000, 1);
      applyStimulus(12'h000, 12'h000, 1);
      applyStimulus(12'h000, 12'h001, 6);
      applyStimulus(12'h000, 12'h000, 4);
    end
    checkOutput("trg_count_saturated", int'(bus.TRG_COUNT), 15);
    checkOutput("timeout_count_sat_run", int'(bus.TIMEOUT_COUNT), 0);

    // Reset while waiting, then a normal trigger.
    $display("[TB] reset mid-wait");
    applyStimulus(12'h001, 12'h000, 1);
    applyStimulus(12'h000, 12'h000, 5);
    checkOutput("busy_before_reset", int'(bus.BUSY), 1);
    rst = 1'b1;
    #1;
    checkIdleOutputs("midreset");
    tick(3);
    rst = 1'b0;
    tick(2);
    c0 = cyc;
    expectResult(c0 + 14, 12'h001, 12'h000, 8'd12);
    applyStimulus(12'h001, 12'h000, 1);
    applyStimulus(12'h000, 12'h000, 9);
    applyStimulus(12'h000, 12'h001, 8);
    applyStimulus(12'h000, 12'h000, 4);
    checkOutput("trg_count_after_reset", int'(bus.TRG_COUNT), 1);

`ifdef TRG_ACK_STICKY_EN
    $display("[TB] sticky missing mask");
    checkOutput("sticky_initial", int'(bus.ACK_MISSING_STICKY), 0);
    bus.TRG_MASK = 12'h003;
    c0 = cyc;
    expectResult(c0 + 202, 12'h001, 12'h002, 8'd255);
    applyStimulus(12'h001, 12'h000, 1);
    applyStimulus(12'h000, 12'h000, 9);
    applyStimulus(12'h000, 12'h001, 195);
    applyStimulus(12'h000, 12'h000, 4);
    checkOutput("sticky_first", int'(bus.ACK_MISSING_STICKY), 12'h002);
    bus.TRG_MASK = 12'h011;
    c0 = cyc;
    expectResult(c0 + 202, 12'h001, 12'h010, 8'd255);
    applyStimulus(12'h001, 12'h000, 1);
    applyStimulus(12'h000, 12'h000, 9);
    applyStimulus(12'h000, 12'h001, 195);
    applyStimulus(12'h000, 12'h000, 4);
    checkOutput("sticky_second", int'(bus.ACK_MISSING_STICKY), 12'h012);
    bus.CLR_STATS = 1'b1;
    tick(1);
    bus.CLR_STATS = 1'b0;
    tick(1);
    checkOutput("sticky_cleared", int'(bus.ACK_MISSING_STICKY), 0);
`endif

    for (int i = 0; i < 400 && sb_q.size() > 0; i++) tick(1);
    checkOutput("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
